// File: rtl/app_axis_pkg.sv
// Shared types and helpers for the application-block AXI-Stream frame transmitter.
// Holds the transmitter FSM encoding and the final-beat strobe mask helper.
package app_axis_pkg;

    localparam int STRB_MAX = 128;
    localparam int STAT_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_e;

    // Low 'rem' bits set; a zero remainder means the final beat is full.
    function automatic logic [STRB_MAX-1:0] strb_mask(input int unsigned rem,
                                                      input int unsigned width);
        logic [STRB_MAX-1:0] m;
        int unsigned         n;
        n = (rem == 0) ? width : rem;
        m = '0;
        for (int unsigned i = 0; i < STRB_MAX; i++) begin
            if (i < n) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/app_axis_tx_stats.sv
// Wrapping frame / beat / stall counters for the AXI-Stream frame transmitter.
// Cleared only by reset.
module app_axis_tx_stats
    import app_axis_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hs_i,
    input  logic              last_i,
    input  logic              stall_i,
    output logic [STAT_W-1:0] frames_o,
    output logic [STAT_W-1:0] beats_o,
    output logic [STAT_W-1:0] stalls_o
);

    logic [STAT_W-1:0] frames_q, frames_d;
    logic [STAT_W-1:0] beats_q,  beats_d;
    logic [STAT_W-1:0] stalls_q, stalls_d;

    always_comb begin
        frames_d = frames_q;
        beats_d  = beats_q;
        stalls_d = stalls_q;
        if (hs_i) begin
            beats_d = beats_q + STAT_W'(1);
            if (last_i) begin
                frames_d = frames_q + STAT_W'(1);
            end
        end
        if (stall_i) begin
            stalls_d = stalls_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_q <= '0;
            beats_q  <= '0;
            stalls_q <= '0;
        end else begin
            frames_q <= frames_d;
            beats_q  <= beats_d;
            stalls_q <= stalls_d;
        end
    end

    assign frames_o = frames_q;
    assign beats_o  = beats_q;
    assign stalls_o = stalls_q;

endmodule

// File: rtl/app_axis_frame_tx.sv
// Descriptor-driven AXI-Stream frame source (seeded incrementing data, TUSER on first beat).
// Statistics counters are built only when APP_AXIS_TX_STATS_EN is defined.
module app_axis_frame_tx
    import app_axis_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int TSTRB_WIDTH     = AXIS_DATA_WIDTH / 8,
    parameter int LEN_WIDTH       = 16,
    parameter int GAP_CYCLES      = 0
)
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [LEN_WIDTH-1:0]       cmd_len,
    input  logic [AXIS_DATA_WIDTH-1:0] cmd_seed,
    output logic                       M_AXIS_TVALID,
    input  logic                       M_AXIS_TREADY,
    output logic [AXIS_DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic [TSTRB_WIDTH-1:0]     M_AXIS_TSTRB,
    output logic                       M_AXIS_TLAST,
    output logic                       M_AXIS_TUSER,
    output logic                       tx_err,
    output logic [31:0]                stat_frames,
    output logic [31:0]                stat_beats,
    output logic [31:0]                stat_stalls
);

    localparam logic [TSTRB_WIDTH-1:0] STRB_ALL = '1;
    localparam logic [7:0] GAP_LOAD = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    tx_state_e                  state_q;
    logic                       cmd_ready_q;
    logic                       tvalid_q;
    logic [AXIS_DATA_WIDTH-1:0] tdata_q;
    logic [TSTRB_WIDTH-1:0]     tstrb_q;
    logic                       tlast_q;
    logic                       tuser_q;
    logic                       tx_err_q;
    logic [LEN_WIDTH-1:0]       cnt_q;
    logic [TSTRB_WIDTH-1:0]     last_strb_q;
    logic [7:0]                 gap_q;

    logic [31:0]                len_rem_d;
    logic [LEN_WIDTH-1:0]       beats_d;
    logic [TSTRB_WIDTH-1:0]     last_strb_d;
    logic                       accept_d;

    // Beat count is derived by division so the maximum length cannot overflow.
    always_comb begin
        len_rem_d   = 32'(cmd_len % TSTRB_WIDTH);
        beats_d     = LEN_WIDTH'(cmd_len / TSTRB_WIDTH) + LEN_WIDTH'(len_rem_d != 0);
        last_strb_d = TSTRB_WIDTH'(strb_mask(len_rem_d, TSTRB_WIDTH));
        accept_d    = cmd_valid && cmd_ready_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tstrb_q     <= '0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
            tx_err_q    <= 1'b0;
            cnt_q       <= '0;
            last_strb_q <= '0;
            gap_q       <= '0;
        end else begin
            tx_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (accept_d) begin
                        if (cmd_len == '0) begin
                            tx_err_q <= 1'b1;
                        end else begin
                            state_q     <= ST_SEND;
                            cmd_ready_q <= 1'b0;
                            tvalid_q    <= 1'b1;
                            tdata_q     <= cmd_seed;
                            tuser_q     <= 1'b1;
                            tlast_q     <= (beats_d == LEN_WIDTH'(1));
                            tstrb_q     <= (beats_d == LEN_WIDTH'(1)) ? last_strb_d : STRB_ALL;
                            last_strb_q <= last_strb_d;
                            cnt_q       <= beats_d - LEN_WIDTH'(1);
                        end
                    end
                end
                ST_SEND: begin
                    if (M_AXIS_TREADY) begin
                        if (tlast_q) begin
                            tvalid_q <= 1'b0;
                            tdata_q  <= '0;
                            tstrb_q  <= '0;
                            tlast_q  <= 1'b0;
                            tuser_q  <= 1'b0;
                            if (GAP_CYCLES > 0) begin
                                state_q <= ST_GAP;
                                gap_q   <= GAP_LOAD;
                            end else begin
                                state_q     <= ST_IDLE;
                                cmd_ready_q <= 1'b1;
                            end
                        end else begin
                            // cnt_q counts beats still to come after the one on the bus.
                            tdata_q <= tdata_q + AXIS_DATA_WIDTH'(1);
                            tuser_q <= 1'b0;
                            cnt_q   <= cnt_q - LEN_WIDTH'(1);
                            tlast_q <= (cnt_q == LEN_WIDTH'(1));
                            tstrb_q <= (cnt_q == LEN_WIDTH'(1)) ? last_strb_q : STRB_ALL;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_q == 8'd0) begin
                        state_q     <= ST_IDLE;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q - 8'd1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b0;
                    tvalid_q    <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TSTRB  = tstrb_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign M_AXIS_TUSER  = tuser_q;
    assign tx_err        = tx_err_q;

`ifdef APP_AXIS_TX_STATS_EN
    logic stat_hs;
    logic stat_stall;

    assign stat_hs    = tvalid_q && M_AXIS_TREADY;
    assign stat_stall = tvalid_q && !M_AXIS_TREADY;

    app_axis_tx_stats u_stats (
        .clk      (clk),
        .rst_n    (rst_n),
        .hs_i     (stat_hs),
        .last_i   (tlast_q),
        .stall_i  (stat_stall),
        .frames_o (stat_frames),
        .beats_o  (stat_beats),
        .stalls_o (stat_stalls)
    );
`else
    assign stat_frames = '0;
    assign stat_beats  = '0;
    assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_app_axis_frame_tx.sv
// Randomized bench for app_axis_frame_tx: two instances (GAP_CYCLES 0 and 3) against a beat-queue model.
module tb_app_axis_frame_tx;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  s;
        logic        l;
        logic        u;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        cmd_valid   [2];
    logic        cmd_ready   [2];
    logic [15:0] cmd_len     [2];
    logic [31:0] cmd_seed    [2];
    logic        tvalid      [2];
    logic        tready      [2];
    logic [31:0] tdata       [2];
    logic [3:0]  tstrb       [2];
    logic        tlast       [2];
    logic        tuser       [2];
    logic        tx_err      [2];
    logic [31:0] stat_frames [2];
    logic [31:0] stat_beats  [2];
    logic [31:0] stat_stalls [2];
    int          tr_mode     [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int GAPV = (g == 0) ? 0 : 3;

        beat_t       q[$];
        beat_t       held;
        logic        held_v     = 1'b0;
        logic        pend_err   = 1'b0;
        logic        pend_first = 1'b0;
        logic        gap_trk    = 1'b0;
        int          gap_cnt    = 0;
        logic [31:0] m_frames   = '0;
        logic [31:0] m_beats    = '0;
        logic [31:0] m_stalls   = '0;

        app_axis_frame_tx #(
            .AXIS_DATA_WIDTH (32),
            .LEN_WIDTH       (16),
            .GAP_CYCLES      (GAPV)
        ) dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .cmd_valid     (cmd_valid[g]),
            .cmd_ready     (cmd_ready[g]),
            .cmd_len       (cmd_len[g]),
            .cmd_seed      (cmd_seed[g]),
            .M_AXIS_TVALID (tvalid[g]),
            .M_AXIS_TREADY (tready[g]),
            .M_AXIS_TDATA  (tdata[g]),
            .M_AXIS_TSTRB  (tstrb[g]),
            .M_AXIS_TLAST  (tlast[g]),
            .M_AXIS_TUSER  (tuser[g]),
            .tx_err        (tx_err[g]),
            .stat_frames   (stat_frames[g]),
            .stat_beats    (stat_beats[g]),
            .stat_stalls   (stat_stalls[g])
        );

        always @(posedge clk) begin
            #1;
            tready[g] = (tr_mode[g] == 0) ? 1'b1 :
                        (tr_mode[g] == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end

        always @(negedge clk) begin : mon
            int    nb;
            int    rem;
            beat_t b;
            if (!rst_n) begin
                q.delete();
                held_v = 1'b0; pend_err = 1'b0; pend_first = 1'b0; gap_trk = 1'b0;
                m_frames = '0; m_beats = '0; m_stalls = '0;
                check_val("rst_tvalid", 64'(tvalid[g]), 64'(0));
                check_val("rst_cmd_ready", 64'(cmd_ready[g]), 64'(0));
                check_val("rst_stats", 64'(stat_frames[g] | stat_beats[g] | stat_stalls[g]), 64'(0));
            end else begin
`ifdef APP_AXIS_TX_STATS_EN
                check_val("stat_frames", 64'(stat_frames[g]), 64'(m_frames));
                check_val("stat_beats", 64'(stat_beats[g]), 64'(m_beats));
                check_val("stat_stalls", 64'(stat_stalls[g]), 64'(m_stalls));
`else
                check_val("stat_frames_off", 64'(stat_frames[g]), 64'(0));
                check_val("stat_beats_off", 64'(stat_beats[g]), 64'(0));
                check_val("stat_stalls_off", 64'(stat_stalls[g]), 64'(0));
`endif
                check_val("tx_err", 64'(tx_err[g]), 64'(pend_err));
                if (pend_err) begin
                    check_val("err_ready", 64'(cmd_ready[g]), 64'(1));
                    check_val("err_tvalid", 64'(tvalid[g]), 64'(0));
                end
                if (pend_first) begin
                    check_val("first_tvalid", 64'(tvalid[g]), 64'(1));
                    check_val("first_tuser", 64'(tuser[g]), 64'(1));
                end
                if (held_v) begin
                    check_val("hold_tvalid", 64'(tvalid[g]), 64'(1));
                    check_val("hold_beat", 64'({tdata[g], tstrb[g], tlast[g], tuser[g]}), 64'(held));
                end
                if (gap_trk) begin
                    if (cmd_ready[g]) begin
                        check_val("gap_len", 64'(gap_cnt), 64'(GAPV));
                        gap_trk = 1'b0;
                    end else begin
                        check_val("gap_tvalid", 64'(tvalid[g]), 64'(0));
                        gap_cnt++;
                        if (gap_cnt > 300) begin
                            check_val("gap_timeout", 64'(cmd_ready[g]), 64'(1));
                            gap_trk = 1'b0;
                        end
                    end
                end
                pend_err = 1'b0; pend_first = 1'b0; held_v = 1'b0;

                if (tvalid[g]) begin
                    if (q.size() == 0) begin
                        check_val("spurious_tvalid", 64'(tvalid[g]), 64'(0));
                    end else if (tready[g]) begin
                        b = q.pop_front();
                        check_val("beat", 64'({tdata[g], tstrb[g], tlast[g], tuser[g]}), 64'(b));
                        m_beats++;
                        if (b.l) begin
                            m_frames++;
                            gap_trk = 1'b1;
                            gap_cnt = 0;
                        end
                    end else begin
                        m_stalls++;
                        held   = {tdata[g], tstrb[g], tlast[g], tuser[g]};
                        held_v = 1'b1;
                    end
                end

                if (cmd_valid[g] && cmd_ready[g]) begin
                    nb  = (int'(cmd_len[g]) + 3) / 4;
                    rem = int'(cmd_len[g]) % 4;
                    for (int k = 0; k < nb; k++) begin
                        b.d = cmd_seed[g] + 32'(k);
                        b.s = (k == nb - 1 && rem != 0) ? 4'((1 << rem) - 1) : 4'hF;
                        b.l = (k == nb - 1);
                        b.u = (k == 0);
                        q.push_back(b);
                    end
                    pend_err   = (nb == 0);
                    pend_first = (nb != 0);
                end
            end
        end
    end

    task automatic send(input int g, input int len, input logic [31:0] seed);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        cmd_valid[g] = 1'b1;
        cmd_len[g]   = 16'(len);
        cmd_seed[g]  = seed;
        forever begin
            @(negedge clk);
            if (cmd_ready[g]) break;
            n++;
            if (n > 20000) begin
                check_val("cmd_timeout", 64'(cmd_ready[g]), 64'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid[g] = 1'b0;
        cmd_len[g]   = 16'($urandom);
        cmd_seed[g]  = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((inst[0].q.size() != 0 || inst[1].q.size() != 0 || !cmd_ready[0] || !cmd_ready[1])
               && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check_val("drain0", 64'(inst[0].q.size()), 64'(0));
        check_val("drain1", 64'(inst[1].q.size()), 64'(0));
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s0;
        for (int g = 0; g < 2; g++) begin
            cmd_valid[g] = 1'b0;
            cmd_len[g]   = '0;
            cmd_seed[g]  = '0;
            tready[g]    = 1'b1;
            tr_mode[g]   = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_tvalid", 64'(tvalid[0]), 64'(0));
        check_val("reset_tdata", 64'(tdata[0]), 64'(0));
        check_val("reset_tx_err", 64'(tx_err[0]), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check_val("ready_before_edge", 64'(cmd_ready[0]), 64'(0));
        @(negedge clk);
        check_val("ready_after_edge", 64'(cmd_ready[0]), 64'(1));

        send(0, 12, 32'hA5A5A5A5);
        send(0, 5, 32'hFFFFFFFF);
        send(0, 4, 32'h00001000);
        send(0, 4, 32'h00002000);
        drain();

        // Stall: sink holds TREADY low for four cycles on a single-beat frame.
        s0 = stat_stalls[0];
        tr_mode[0] = 2;
        send(0, 3, 32'h12345678);
        repeat (4) @(posedge clk);
        tr_mode[0] = 0;
        repeat (4) @(negedge clk);
`ifdef APP_AXIS_TX_STATS_EN
        check_val("stall_delta", 64'(stat_stalls[0] - s0), 64'(4));
`else
        check_val("stall_delta", 64'(stat_stalls[0] - s0), 64'(0));
`endif

        send(0, 0, 32'hDEADBEEF);
        repeat (3) @(negedge clk);
        check_val("zero_len_ready", 64'(cmd_ready[0]), 64'(1));

        send(1, 8, 32'h0000AA00);
        send(1, 4, 32'h0000BB00);
        send(1, 1, 32'h0000CC00);
        drain();

        send(0, 65535, $urandom);
        drain();

        // Reset in the middle of beat 2 of an 8-beat frame.
        send(0, 32, 32'h50000000);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_tvalid", 64'(tvalid[0]), 64'(0));
        check_val("async_tlast", 64'(tlast[0]), 64'(0));
        check_val("async_tdata", 64'(tdata[0]), 64'(0));
        check_val("async_ready", 64'(cmd_ready[0]), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(0, 32, 32'h60000000);
        drain();

        tr_mode[0] = 1;
        tr_mode[1] = 1;
        fork
            for (int i = 0; i < 30; i++) begin
                send(0, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40)), $urandom);
            end
            for (int j = 0; j < 30; j++) begin
                send(1, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40)), $urandom);
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
        join
        tr_mode[0] = 0;
        tr_mode[1] = 0;
        drain();
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/app_axis_frame_tx.md
# app_axis_frame_tx

Command-driven AXI-Stream master for the application block: accepts one frame descriptor (byte length, data seed), emits the frame on `M_AXIS_*` beat by beat under `M_AXIS_TREADY` backpressure, then returns idle. It is the transmit counterpart of the application-block stream receiver, using the same TDATA/TSTRB/TLAST/TVALID/TUSER signal set, with TUSER marking the first beat of a frame. It serves as the on-chip traffic source for loopback and bring-up of the `S_AXIS` path.

## Interface
- `AXIS_DATA_WIDTH`, 32, data width in bits; multiple of 8.
- `TSTRB_WIDTH`, `AXIS_DATA_WIDTH/8`, bytes per beat.
- `LEN_WIDTH`, 16, width of the frame byte-length field.
- `GAP_CYCLES`, 0, forced idle cycles after each frame's last beat; range 0..255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `cmd_valid` in 1: descriptor valid.
- `cmd_ready` out 1: descriptor accepted when `cmd_valid && cmd_ready`.
- `cmd_len` in `LEN_WIDTH`: frame length in bytes.
- `cmd_seed` in `AXIS_DATA_WIDTH`: TDATA of the first beat.
- `M_AXIS_TVALID` out 1: beat valid.
- `M_AXIS_TREADY` in 1: sink ready.
- `M_AXIS_TDATA` out `AXIS_DATA_WIDTH`: beat data.
- `M_AXIS_TSTRB` out `TSTRB_WIDTH`: byte qualifiers.
- `M_AXIS_TLAST` out 1: last beat of frame.
- `M_AXIS_TUSER` out 1: first beat of frame.
- `tx_err` out 1: one-cycle pulse when a zero-length descriptor is accepted.
- `stat_frames`, `stat_beats`, `stat_stalls` out 32 each: statistics (see Configuration).

## Operation
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - `cmd_ready`=1.
  - On accept with `cmd_len`≠0: latch the seed, set beats = ceil(`cmd_len`/`TSTRB_WIDTH`), go to SEND.
  - On accept with `cmd_len`=0: pulse `tx_err`, stay in IDLE, emit nothing.
- SEND:
  - `cmd_ready`=0 and `M_AXIS_TVALID`=1.
  - Beat k (0-based) carries TDATA = seed + k, modulo 2^`AXIS_DATA_WIDTH`.
  - TUSER=1 only on beat 0. TLAST=1 only on the final beat.
  - TSTRB is all ones, except on the final beat it is the low (`cmd_len` mod `TSTRB_WIDTH`) bits set, or all ones if that remainder is 0.
  - A single-beat frame has TUSER=TLAST=1.
  - The beat advances only on `M_AXIS_TVALID && M_AXIS_TREADY`.
  - On the last-beat handshake, go to GAP if `GAP_CYCLES`>0, otherwise to IDLE.
- GAP: `cmd_ready`=0 and TVALID=0. Count `GAP_CYCLES` cycles, then go to IDLE.
- AXI-Stream rules:
  - Once TVALID is asserted, TVALID, TDATA, TSTRB, TLAST and TUSER stay stable until the handshake.
  - TVALID never depends combinationally on TREADY.
- The beat counter is `LEN_WIDTH` bits. The maximum length 2^`LEN_WIDTH`-1 must not overflow.

## Timing
- Reset values: `cmd_ready`=0 while `rst_n`=0 and 1 from the first clock edge after deassertion. All `M_AXIS_*` outputs, `tx_err` and all stats are 0. State is IDLE.
- All outputs are registered.
- Descriptor accepted at edge N: first beat valid after edge N, with TUSER=1.
- With TREADY held at 1, an F-beat frame takes F consecutive cycles.
- When `GAP_CYCLES`=0, `cmd_ready` rises the cycle after the last handshake. Back-to-back frames are therefore separated by exactly one idle cycle.
- `rst_n` asserted mid-frame: TVALID drops immediately (asynchronously), the frame is abandoned, and no TLAST is emitted.
- `cmd_valid` asserted in SEND or GAP is ignored. The sender holds the descriptor until `cmd_ready`.

## Configuration
- `APP_AXIS_TX_STATS_EN` defined:
  - `stat_frames` increments on each last-beat handshake.
  - `stat_beats` increments on each handshake.
  - `stat_stalls` increments on each cycle with TVALID=1 and TREADY=0.
  - All three wrap modulo 2^32 and clear only on reset.
- Not defined: the counters are not built and the stat ports are tied to 0. The port list is identical either way.

## Structure
- Package `app_axis_pkg`: FSM state enum (IDLE/SEND/GAP) and the strobe-mask helper function (remainder to TSTRB).
- Sub-module `app_axis_tx_stats`: the three counters, instantiated only under `APP_AXIS_TX_STATS_EN`.

## Test plan
- `cmd_len`=12, seed=32'hA5A5A5A5, TREADY=1 → 3 beats: A5A5A5A5 (TUSER=1), A5A5A5A6, A5A5A5A7 (TLAST=1); TSTRB=4'b1111 on all beats.
- `cmd_len`=5, seed=32'hFFFFFFFF → 2 beats: FFFFFFFF, then 00000000 with TSTRB=4'b0001 and TLAST=1 (data wraps).
- `cmd_len`=3, TREADY low for 4 cycles → TVALID held with stable data for 4 cycles; one beat with TUSER=TLAST=1 and TSTRB=4'b0111; `stat_stalls`=4 when the macro is defined.
- `cmd_len`=0 → `tx_err` high for one cycle, TVALID stays 0, `cmd_ready` stays 1.
- `GAP_CYCLES`=3, two frames queued → exactly 3 cycles with TVALID=0 between the first frame's TLAST and the next frame's `cmd_ready`.
- `rst_n` pulsed low mid-beat 2 of an 8-beat frame → outputs 0 immediately; the next frame restarts from beat 0 with TUSER=1.
